// File: rtl/iface_byte_reader.sv
// Reader end of an 8-bit valid/ready data interface: small FIFO, checked pops, idle watchdog FSM.
// Optional odd-parity checking on incoming beats when IFACE_READER_PARITY_EN is defined.
module iface_byte_reader #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic [WIDTH-1:0]           if_data,
`ifdef IFACE_READER_PARITY_EN
  input  logic                       if_parity,
  output logic                       par_err,
`endif
  output logic                       if_ready,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [WIDTH-1:0]           exp_data,
  input  logic                       exp_check,
  input  logic                       clr,
  output logic                       err,
  output logic [15:0]                match_cnt,
  output logic [1:0]                 state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    TMO    = 2'd2
  } st_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty;
  logic             acc, stall, wr, pop;
  st_t              st_q, st_d;
  logic [15:0]      idle_q, idle_d;

  // One extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign if_ready = ~full;
  assign rd_empty = empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign count    = CW'(wr_ptr - rd_ptr);
  assign state    = st_q;

  assign acc   = if_valid & if_ready;
  assign stall = if_valid & ~if_ready;
  assign pop   = rd_en & ~empty;

`ifdef IFACE_READER_PARITY_EN
  logic par_ok;
  assign par_ok = ^{if_data, if_parity};
  assign wr     = acc & par_ok;
`else
  assign wr     = acc;
`endif

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= if_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      match_cnt <= '0;
    end else if (clr) begin
      err       <= 1'b0;
      match_cnt <= '0;
    end else if (pop && exp_check) begin
      if (rd_data != exp_data)     err       <= 1'b1;
      else if (match_cnt != 16'hFFFF) match_cnt <= match_cnt + 16'd1;
    end
  end

`ifdef IFACE_READER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst || clr)           par_err <= 1'b0;
    else if (acc && !par_ok)  par_err <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      idle_q <= '0;
    end else begin
      st_q   <= st_d;
      idle_q <= idle_d;
    end
  end

  // Back-pressured beats are not idle time, so the watchdog holds during a stall.
  always_comb begin
    st_d   = st_q;
    idle_d = idle_q;
    case (st_q)
      IDLE: begin
        if (acc) begin
          st_d   = ACTIVE;
          idle_d = '0;
        end
      end
      ACTIVE: begin
        if (acc)
          idle_d = '0;
        else if (!stall) begin
          if (idle_q == 16'(TIMEOUT-1)) st_d = TMO;
          else                          idle_d = idle_q + 16'd1;
        end
      end
      TMO: begin
        if (acc) begin
          st_d   = ACTIVE;
          idle_d = '0;
        end
      end
      default: st_d = IDLE;
    endcase
    if (clr) begin
      idle_d = '0;
      st_d   = acc ? ACTIVE : IDLE;
    end
  end

endmodule
